alu_share_ctrl: RTL and testbench



---
 rtl/alu_opcodes_pkg.sv | 46 ++++
 rtl/alu.sv | 42 ++++
 rtl/rr_arbiter.sv | 33 +++
 rtl/alu_share_ctrl.sv | 140 ++++++++++++++
 tb/tb_alu_share_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_opcodes_pkg.sv
// Shared ALU opcode map, legality check, ALU-sharing FSM state and operand bundle.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package alu_opcodes_pkg;

    localparam int ALU_OP_W = 5;

    // Result ops: flag is always 0.
    localparam logic [ALU_OP_W-1:0] OP_ADD  = 5'd0;
    localparam logic [ALU_OP_W-1:0] OP_SUB  = 5'd1;
    localparam logic [ALU_OP_W-1:0] OP_AND  = 5'd2;
    localparam logic [ALU_OP_W-1:0] OP_OR   = 5'd3;
    localparam logic [ALU_OP_W-1:0] OP_XOR  = 5'd4;
    localparam logic [ALU_OP_W-1:0] OP_SLL  = 5'd5;
    localparam logic [ALU_OP_W-1:0] OP_SRL  = 5'd6;
    localparam logic [ALU_OP_W-1:0] OP_SRA  = 5'd7;
    localparam logic [ALU_OP_W-1:0] OP_SLTS = 5'd8;
    localparam logic [ALU_OP_W-1:0] OP_SLTU = 5'd9;

    // Flag ops: result is always 0.
    localparam logic [ALU_OP_W-1:0] OP_EQ   = 5'd16;
    localparam logic [ALU_OP_W-1:0] OP_NE   = 5'd17;
    localparam logic [ALU_OP_W-1:0] OP_LTS  = 5'd18;
    localparam logic [ALU_OP_W-1:0] OP_GES  = 5'd19;
    localparam logic [ALU_OP_W-1:0] OP_LTU  = 5'd20;
    localparam logic [ALU_OP_W-1:0] OP_GEU  = 5'd21;

    // Ten result ops occupy 0..9, six flag ops occupy 16..21; everything else is undefined.
    function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
        return (op <= OP_SLTU) || ((op >= OP_EQ) && (op <= OP_GEU));
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_share_state_t;

    // Operands latched at accept time; the ALU only ever sees this bundle.
    typedef struct packed {
        logic [ALU_OP_W-1:0] op;
        logic [31:0]         a;
        logic [31:0]         b;
    } alu_req_t;

endpackage

// File: rtl/alu.sv
// 32-bit integer ALU: result ops and comparison-flag ops, undefined ops yield 0/0.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module alu
    import alu_opcodes_pkg::*;
(
    input  logic [31:0]         a_i,
    input  logic [31:0]         b_i,
    input  logic [ALU_OP_W-1:0] op_i,
    output logic [31:0]         result_o,
    output logic                flag_o
);

    logic [4:0] shamt;
    assign shamt = b_i[4:0];

    // Decode the opcode; shift amount is limited to 5 bits here, not by callers.
    always_comb begin
        result_o = '0;
        flag_o   = 1'b0;
        case (op_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_SLL:  result_o = a_i << shamt;
            OP_SRL:  result_o = a_i >> shamt;
            OP_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
            OP_SLTS: result_o = {31'd0, $signed(a_i) < $signed(b_i)};
            OP_SLTU: result_o = {31'd0, a_i < b_i};
            OP_EQ:   flag_o   = (a_i == b_i);
            OP_NE:   flag_o   = (a_i != b_i);
            OP_LTS:  flag_o   = ($signed(a_i) < $signed(b_i));
            OP_GES:  flag_o   = ($signed(a_i) >= $signed(b_i));
            OP_LTU:  flag_o   = (a_i < b_i);
            OP_GEU:  flag_o   = (a_i >= b_i);
            default: ;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set valid bit strictly after ptr_i, wrapping, as one-hot and index.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is taken.
module rr_arbiter #(
    parameter int N    = 2,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    valid_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [N-1:0]    grant_o,
    output logic [ID_W-1:0] idx_o,
    output logic            any_o
);

    int scan_j;

    // Scan ptr+1 .. ptr+N modulo N so the last winner has the lowest priority.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        scan_j  = 0;
        for (int k = 1; k <= N; k++) begin
            scan_j = (int'(ptr_i) + k) % N;
            if (!any_o && valid_i[scan_j]) begin
                any_o           = 1'b1;
                grant_o[scan_j] = 1'b1;
                idx_o           = ID_W'(scan_j);
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between NUM_REQ requesters: round-robin accept, one op, response to the owner.
// Latency: accept at edge N, response valid after edge N+1; one op per 2 cycles at best.
// Backpressure: a stalled response holds the block in RESP and keeps every req_ready_o low.
module alu_share_ctrl
    import alu_opcodes_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ*32-1:0]        req_a_i,
    input  logic [NUM_REQ*32-1:0]        req_b_i,
    input  logic [NUM_REQ*ALU_OP_W-1:0]  req_op_i,
    output logic [NUM_REQ-1:0]           rsp_valid_o,
    input  logic [NUM_REQ-1:0]           rsp_ready_i,
    output logic [31:0]                  rsp_result_o,
    output logic                         rsp_flag_o,
    output logic                         rsp_err_o,
    output logic                         busy_o
);

    alu_share_state_t   state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    id_q;
    alu_req_t           opnd_q;
    alu_req_t           opnd_d;
    logic [31:0]        result_q;
    logic               flag_q;
    logic               err_q;
    logic [NUM_REQ-1:0] rsp_valid_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;
    logic               rsp_done;
    logic               can_accept;
    logic               accept;
    logic [31:0]        alu_result;
    logic               alu_flag;
    logic               op_legal;

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .valid_i (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    alu u_alu (
        .a_i      (opnd_q.a),
        .b_i      (opnd_q.b),
        .op_i     (opnd_q.op),
        .result_o (alu_result),
        .flag_o   (alu_flag)
    );

    assign op_legal = alu_op_legal(opnd_q.op);

    // Only the owner's ready retires a response; other requesters' ready bits are don't-care.
    assign rsp_done   = (state_q == RESP) && rsp_ready_i[id_q];
    // A new op may be taken from IDLE, or in the same cycle the current response retires.
    assign can_accept = (state_q == IDLE) || rsp_done;
    assign accept     = can_accept && arb_any;

    // Grant is combinational off the arbiter; forced low while in reset so outputs read 0.
    always_comb begin
        req_ready_o = '0;
        if (rst_ni && can_accept) begin
            req_ready_o = arb_grant;
        end
    end

    // Operands of the requester the arbiter currently selects, latched on accept.
    always_comb begin
        opnd_d.op = req_op_i[arb_idx*ALU_OP_W +: ALU_OP_W];
        opnd_d.a  = req_a_i[arb_idx*32 +: 32];
        opnd_d.b  = req_b_i[arb_idx*32 +: 32];
    end

    // Sequencer: IDLE -> EXEC -> RESP, with RESP -> EXEC when a request is waiting at retire.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ptr_q       <= ID_W'(NUM_REQ - 1);
            id_q        <= '0;
            opnd_q      <= '0;
            result_q    <= '0;
            flag_q      <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        opnd_q  <= opnd_d;
                        id_q    <= arb_idx;
                        ptr_q   <= arb_idx;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    // Undefined ops complete normally but report err with a zeroed payload.
                    result_q    <= op_legal ? alu_result : '0;
                    flag_q      <= op_legal ? alu_flag : 1'b0;
                    err_q       <= !op_legal;
                    rsp_valid_q <= NUM_REQ'(1) << id_q;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        rsp_valid_q <= '0;
                        if (accept) begin
                            opnd_q  <= opnd_d;
                            id_q    <= arb_idx;
                            ptr_q   <= arb_idx;
                            state_q <= EXEC;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = result_q;
    assign rsp_flag_o   = flag_q;
    assign rsp_err_o    = err_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl with three requesters: directed scenarios plus random traffic.
// Latency: n/a.
// Backpressure: random response stalls exercised against a transaction-level model.
module tb_alu_share_ctrl;

    localparam int N = 3;

    typedef struct packed {
        logic [31:0] res;
        logic        flag;
        logic        err;
    } rsp_t;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready_o;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N*5-1:0]  req_op;
    logic [N-1:0]    rsp_valid_o;
    logic [N-1:0]    rsp_ready;
    logic [31:0]     rsp_result_o;
    logic            rsp_flag_o;
    logic            rsp_err_o;
    logic            busy_o;

    int checks = 0;
    int errors = 0;

    alu_share_ctrl #(.NUM_REQ(N)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready_o),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_op_i     (req_op),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result_o),
        .rsp_flag_o   (rsp_flag_o),
        .rsp_err_o    (rsp_err_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Architectural meaning of each opcode, independent of any hardware structure.
    function automatic rsp_t ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        rsp_t r;
        r = '0;
        case (op)
            5'd0:  r.res = a + b;
            5'd1:  r.res = a - b;
            5'd2:  r.res = a & b;
            5'd3:  r.res = a | b;
            5'd4:  r.res = a ^ b;
            5'd5:  r.res = a << b[4:0];
            5'd6:  r.res = a >> b[4:0];
            5'd7:  r.res = $signed(a) >>> b[4:0];
            5'd8:  r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd9:  r.res = (a < b) ? 32'd1 : 32'd0;
            5'd16: r.flag = (a == b);
            5'd17: r.flag = (a != b);
            5'd18: r.flag = ($signed(a) < $signed(b));
            5'd19: r.flag = ($signed(a) >= $signed(b));
            5'd20: r.flag = (a < b);
            5'd21: r.flag = (a >= b);
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Model: who owns the ALU, how long since accept, last winner, pending response.
    int   m_owner = -1;
    int   m_age   = 0;
    int   m_last  = N - 1;
    rsp_t m_rsp   = '0;

    function automatic logic model_done();
        return (m_owner >= 0) && (m_age >= 1) && rsp_ready[m_owner];
    endfunction

    function automatic int model_grant();
        if (!rst_n) return -1;
        if ((m_owner < 0) || model_done()) return rr_pick(req_valid, m_last);
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        return (model_grant() >= 0) ? (N'(1) << model_grant()) : '0;
    endfunction

    function automatic logic [N-1:0] exp_rsp_valid();
        return ((m_owner >= 0) && (m_age >= 1)) ? (N'(1) << m_owner) : '0;
    endfunction

    function automatic logic [31:0] a_of(input int i); return req_a[i*32 +: 32]; endfunction
    function automatic logic [31:0] b_of(input int i); return req_b[i*32 +: 32]; endfunction
    function automatic logic [4:0]  op_of(input int i); return req_op[i*5 +: 5]; endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_age   <= 0;
            m_last  <= N - 1;
            m_rsp   <= '0;
        end else if (model_grant() >= 0) begin
            m_owner <= model_grant();
            m_age   <= 0;
            m_last  <= model_grant();
            m_rsp   <= ref_alu(op_of(model_grant()), a_of(model_grant()), b_of(model_grant()));
        end else if (model_done()) begin
            m_owner <= -1;
        end else if (m_owner >= 0) begin
            m_age   <= 1;
        end
    end

    // ---------------- drive helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[i*5 +: 5]  = op;
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = '0;
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    // Run one operation on requester i and return the response it received.
    task automatic issue(input int i, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output rsp_t got, output bit ok);
        int n;
        ok  = 1'b0;
        got = '0;
        set_req(i, op, a, b);
        req_valid[i] = 1'b1;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready_o[i]) break;
        end
        if (n == 20) begin
            req_valid[i] = 1'b0;
            return;
        end
        cyc();
        req_valid[i] = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rsp_valid_o[i]) break;
        end
        if (n == 20) return;
        got = {rsp_result_o, rsp_flag_o, rsp_err_o};
        cyc();
        rsp_ready[i] = 1'b1;
        cyc();
        rsp_ready[i] = 1'b0;
        ok = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        #1 rst_n = 1'b0;
        cyc();
        @(negedge clk);
        checks++; if (req_ready_o !== 3'b000) begin errors++; $display("FAIL reset_ready got %b exp 000", req_ready_o); end
        checks++; if (rsp_valid_o !== 3'b000) begin errors++; $display("FAIL reset_rsp_valid got %b exp 000", rsp_valid_o); end
        checks++; if (rsp_result_o !== 32'd0) begin errors++; $display("FAIL reset_result got %h exp 0", rsp_result_o); end
        checks++; if ({rsp_flag_o, rsp_err_o, busy_o} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {rsp_flag_o, rsp_err_o, busy_o}); end
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        set_req(0, 5'd0, 32'd5, 32'd7);
        req_valid = 3'b001;
        @(negedge clk);
        checks++; if (req_ready_o !== 3'b001) begin errors++; $display("FAIL single_ready got %b exp 001", req_ready_o); end
        cyc();
        req_valid = 3'b000;
        @(negedge clk);
        checks++; if ({rsp_valid_o, busy_o} !== 4'b0001) begin errors++; $display("FAIL single_exec got %b exp 0001", {rsp_valid_o, busy_o}); end
        cyc();
        @(negedge clk);
        checks++; if (rsp_valid_o !== 3'b001) begin errors++; $display("FAIL single_rsp_valid got %b exp 001", rsp_valid_o); end
        checks++; if ({rsp_result_o, rsp_flag_o, rsp_err_o} !== {32'd12, 2'b00}) begin errors++; $display("FAIL single_rsp got %h/%b/%b exp 0000000c/0/0", rsp_result_o, rsp_flag_o, rsp_err_o); end
        cyc();
        rsp_ready = 3'b001;
        cyc();
        rsp_ready = 3'b000;
        @(negedge clk);
        checks++; if ({rsp_valid_o, busy_o} !== 4'b0000) begin errors++; $display("FAIL single_retire got %b exp 0000", {rsp_valid_o, busy_o}); end
    endtask

    task automatic test_contention();
        int n;
        do_reset();
        set_req(0, 5'd0, 32'd1, 32'd1);
        set_req(1, 5'd1, 32'd3, 32'd5);
        req_valid = 3'b011;
        rsp_ready = 3'b111;
        n = 0;
        for (int c = 0; c < 30 && n < 4; c++) begin
            @(negedge clk);
            if (rsp_valid_o[1]) begin
                checks++; if (rsp_result_o !== 32'hFFFF_FFFE) begin errors++; $display("FAIL cont_sub got %h exp fffffffe", rsp_result_o); end
            end
            if (rsp_valid_o[0]) begin
                checks++; if (rsp_result_o !== 32'd2) begin errors++; $display("FAIL cont_add got %h exp 2", rsp_result_o); end
            end
            if (req_ready_o != '0) begin
                checks++; if (req_ready_o !== (N'(1) << (n % 2))) begin errors++; $display("FAIL cont_grant%0d got %b exp %b", n, req_ready_o, N'(1) << (n % 2)); end
                n++;
            end
            cyc();
        end
        req_valid = 3'b000;
        checks++; if (n != 4) begin errors++; $display("FAIL cont_timeout got %0d grants exp 4", n); end
        for (int c = 0; c < 10 && busy_o; c++) cyc();
        rsp_ready = 3'b000;
    endtask

    task automatic test_flag();
        rsp_t r;
        bit ok;
        issue(1, 5'd18, 32'hFFFF_FFFF, 32'd1, r, ok);
        checks++; if (!ok || r !== {32'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL flag_lts got ok=%0d %h exp %h", ok, r, {32'd0, 1'b1, 1'b0}); end
        issue(1, 5'd20, 32'hFFFF_FFFF, 32'd1, r, ok);
        checks++; if (!ok || r !== {32'd0, 1'b0, 1'b0}) begin errors++; $display("FAIL flag_ltu got ok=%0d %h exp %h", ok, r, {32'd0, 1'b0, 1'b0}); end
        issue(2, 5'd7, 32'h8000_0000, 32'h0000_0024, r, ok);
        checks++; if (!ok || r !== {32'hF800_0000, 1'b0, 1'b0}) begin errors++; $display("FAIL sra_shamt got ok=%0d %h exp %h", ok, r, {32'hF800_0000, 1'b0, 1'b0}); end
    endtask

    task automatic test_stall_b2b();
        int n;
        set_req(0, 5'd0, 32'd10, 32'd20);
        req_valid = 3'b001;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready_o[0]) break;
        end
        checks++; if (n == 20) begin errors++; $display("FAIL stall_grant0 got none exp 001"); end
        cyc();
        req_valid = 3'b010;
        set_req(1, 5'd4, 32'hF0F0_1234, 32'h0FF0_FFFF);
        rsp_ready = 3'b110;
        cyc();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if ({rsp_valid_o, req_ready_o, busy_o} !== {3'b001, 3'b000, 1'b1}) begin errors++; $display("FAIL stall_hold%0d got %b/%b/%b exp 001/000/1", c, rsp_valid_o, req_ready_o, busy_o); end
            checks++; if (rsp_result_o !== 32'd30) begin errors++; $display("FAIL stall_result%0d got %h exp 1e", c, rsp_result_o); end
            cyc();
        end
        rsp_ready = 3'b001;
        @(negedge clk);
        checks++; if (req_ready_o !== 3'b010) begin errors++; $display("FAIL b2b_grant got %b exp 010", req_ready_o); end
        cyc();
        rsp_ready = 3'b000;
        req_valid = 3'b000;
        @(negedge clk);
        checks++; if ({rsp_valid_o, busy_o} !== 4'b0001) begin errors++; $display("FAIL b2b_exec got %b exp 0001", {rsp_valid_o, busy_o}); end
        cyc();
        @(negedge clk);
        checks++; if ({rsp_valid_o, rsp_result_o} !== {3'b010, 32'hFF00_EDCB}) begin errors++; $display("FAIL b2b_rsp got %b/%h exp 010/ff00edcb", rsp_valid_o, rsp_result_o); end
        cyc();
        rsp_ready = 3'b010;
        cyc();
        rsp_ready = 3'b000;
    endtask

    task automatic test_illegal();
        rsp_t r;
        bit ok;
        issue(0, 5'h1F, $urandom, $urandom, r, ok);
        checks++; if (!ok || r !== {32'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL illegal got ok=%0d %h exp %h", ok, r, {32'd0, 1'b0, 1'b1}); end
        issue(0, 5'd0, 32'd3, 32'd4, r, ok);
        checks++; if (!ok || r !== {32'd7, 1'b0, 1'b0}) begin errors++; $display("FAIL after_illegal got ok=%0d %h exp %h", ok, r, {32'd7, 1'b0, 1'b0}); end
    endtask

    task automatic test_reset_mid();
        set_req(0, 5'd0, 32'd100, 32'd1);
        req_valid = 3'b001;
        for (int c = 0; c < 20 && !req_ready_o[0]; c++) @(negedge clk);
        cyc();
        req_valid = 3'b010;
        @(negedge clk);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_exec got busy=%b exp 1", busy_o); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({req_ready_o, rsp_valid_o, busy_o, rsp_result_o} !== '0) begin errors++; $display("FAIL mid_reset got %b/%b/%b/%h exp all 0", req_ready_o, rsp_valid_o, busy_o, rsp_result_o); end
        cyc();
        cyc();
        set_req(0, 5'd1, 32'd9, 32'd4);
        req_valid = 3'b011;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({req_ready_o, rsp_valid_o} !== 6'b001_000) begin errors++; $display("FAIL mid_first got %b/%b exp 001/000", req_ready_o, rsp_valid_o); end
        cyc();
        req_valid = 3'b000;
        @(negedge clk);
        checks++; if (rsp_valid_o !== 3'b000) begin errors++; $display("FAIL mid_stale got %b exp 000", rsp_valid_o); end
        cyc();
        @(negedge clk);
        checks++; if ({rsp_valid_o, rsp_result_o} !== {3'b001, 32'd5}) begin errors++; $display("FAIL mid_rsp got %b/%h exp 001/5", rsp_valid_o, rsp_result_o); end
        cyc();
        rsp_ready = 3'b001;
        cyc();
        rsp_ready = 3'b000;
    endtask

    task automatic test_random();
        logic [4:0] legal_ops [16] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                                       5'd8, 5'd9, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21};
        logic [N-1:0] acc;
        int rsp_cnt [N];
        logic [4:0] op;
        for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = req_ready_o;
            checks++; if (req_ready_o !== exp_ready()) begin errors++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, req_ready_o, exp_ready()); end
            checks++; if (rsp_valid_o !== exp_rsp_valid()) begin errors++; $display("FAIL rnd_rsp_valid c=%0d got %b exp %b", c, rsp_valid_o, exp_rsp_valid()); end
            checks++; if (busy_o !== (m_owner >= 0)) begin errors++; $display("FAIL rnd_busy c=%0d got %b exp %b", c, busy_o, m_owner >= 0); end
            if (exp_rsp_valid() != '0) begin
                checks++; if ({rsp_result_o, rsp_flag_o, rsp_err_o} !== m_rsp) begin errors++; $display("FAIL rnd_rsp c=%0d got %h exp %h", c, {rsp_result_o, rsp_flag_o, rsp_err_o}, m_rsp); end
                if (model_done()) rsp_cnt[m_owner]++;
            end
            cyc();
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && acc[i]) begin
                    req_valid[i] = 1'b0;
                end else if (req_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : legal_ops[$urandom_range(0, 15)];
                    set_req(i, op, $urandom, ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
                    req_valid[i] = 1'b1;
                end
                rsp_ready[i] = ($urandom_range(0, 2) != 0);
            end
        end
        req_valid = '0;
        rsp_ready = '1;
        for (int c = 0; c < 10 && busy_o; c++) cyc();
        rsp_ready = '0;
        for (int i = 0; i < N; i++) begin
            checks++; if (rsp_cnt[i] == 0) begin errors++; $display("FAIL rnd_served%0d got 0 responses exp >0", i); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_flag();
        test_stall_b2b();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
